// File: rtl/jcs_scan_pkg.sv
// Shared constants for the jRAM read-back scanner: FSM encoding and the ASCII
// characters used to build the display word.
package jcs_scan_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETADDR = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETADDR = ST_SETADDR,
    S_READ    = ST_READ,
    S_HOLD    = ST_HOLD,
    S_DONE    = ST_DONE
  } state_t;

  localparam logic [7:0] DASH = 8'h2D;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] LC_A = 8'h61;

endpackage

// File: rtl/jcs_ram_scanner_hex_ascii.sv
// Combinational nibble-to-ASCII converter: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'.
module hex_ascii
  import jcs_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  always_comb begin
    o_char = ZERO;
    if (i_nib < 4'd10) o_char = ZERO + {4'd0, i_nib};
    else               o_char = LC_A + {4'd0, i_nib} - 8'd10;
  end

endmodule

// File: rtl/jcs_ram_scanner.sv
// Autonomous jRAM reader: strobes set-address then enable for each address in
// [FIRST_ADDR, LAST_ADDR], captures the byte, and presents it as an ASCII word.
module jcs_ram_scanner
  import jcs_scan_pkg::*;
#(
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned DWELL      = 100000000,
  parameter logic [7:0]  FIRST_ADDR = 8'h00,
  parameter logic [7:0]  LAST_ADDR  = 8'hFF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        step_mode,
  input  logic        loop,
  output logic [7:0]  ram_addr,
  output logic        ram_sa,
  output logic        ram_e,
  input  logic [7:0]  ram_data_in,
  output logic [7:0]  cur_addr,
  output logic [7:0]  cur_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] word,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
  localparam logic [26:0] DWELL_M1  = 27'(DWELL - 1);

  state_t      r_state;
  logic [7:0]  r_ram_addr;
  logic        r_ram_sa;
  logic        r_ram_e;
  logic [7:0]  r_cur_addr;
  logic [7:0]  r_cur_data;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_word;
  logic [15:0] r_strobe_cnt;
  logic [26:0] r_dwell_cnt;

  logic [15:0] w_nibs;
  logic [31:0] w_word;
  logic        w_hold_exit;

  // Word is built from the byte being captured, so it lands on the capture edge.
  assign w_nibs = {r_ram_addr, ram_data_in};

  for (genvar g = 0; g < 4; g++) begin : g_hex
    hex_ascii u_hex (
      .i_nib  (w_nibs[4*g +: 4]),
      .o_char (w_word[8*g +: 8])
    );
  end

  assign w_hold_exit = step_mode ? step : (r_dwell_cnt == DWELL_M1);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ram_addr   <= FIRST_ADDR;
      r_ram_sa     <= 1'b0;
      r_ram_e      <= 1'b0;
      r_cur_addr   <= 8'h00;
      r_cur_data   <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word       <= {4{DASH}};
      r_strobe_cnt <= 16'd0;
      r_dwell_cnt  <= 27'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            r_state      <= S_SETADDR;
            r_ram_addr   <= FIRST_ADDR;
            r_ram_sa     <= 1'b1;
            r_strobe_cnt <= 16'd0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        S_SETADDR: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_ram_sa <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_strobe_cnt == SETTLE_M1) begin
            r_state      <= S_READ;
            r_ram_sa     <= 1'b0;
            r_ram_e      <= 1'b1;
            r_strobe_cnt <= 16'd0;
          end else begin
            r_strobe_cnt <= r_strobe_cnt + 16'd1;
          end
        end
        S_READ: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_ram_e <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_strobe_cnt == SETTLE_M1) begin
            r_state     <= S_HOLD;
            r_ram_e     <= 1'b0;
            r_cur_addr  <= r_ram_addr;
            r_cur_data  <= ram_data_in;
            r_word      <= w_word;
            r_dwell_cnt <= 27'd0;
          end else begin
            r_strobe_cnt <= r_strobe_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_hold_exit) begin
            if (r_ram_addr != LAST_ADDR || loop) begin
              r_state      <= S_SETADDR;
              r_ram_addr   <= (r_ram_addr != LAST_ADDR) ? r_ram_addr + 8'd1 : FIRST_ADDR;
              r_ram_sa     <= 1'b1;
              r_strobe_cnt <= 16'd0;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (step_mode) begin
            // Holding the count at zero in step mode restarts the dwell on a toggle back.
            r_dwell_cnt <= 27'd0;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 27'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ram_sa <= 1'b0;
          r_ram_e  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_sa    = r_ram_sa;
  assign ram_e     = r_ram_e;
  assign cur_addr  = r_cur_addr;
  assign cur_data  = r_cur_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign word      = r_word;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jcs_ram_scanner.sv
// Bench for jcs_ram_scanner: directed scenarios with literal expectations plus
// random click traffic, all compared every cycle against a slot-position model.
module tb_jcs_ram_scanner;

  localparam int          S  = 2;
  localparam int          DW = 4;
  localparam logic [7:0]  FA = 8'h00;
  localparam logic [7:0]  LA = 8'h03;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, step_mode = 1'b0, loop = 1'b0;
  logic [7:0]  ram_addr, ram_data_in, cur_addr, cur_data;
  logic        ram_sa, ram_e, busy, done;
  logic [31:0] word;
  logic [2:0]  dbg_state;
  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  always #5 CLK = ~CLK;

  assign ram_data_in = mem[ram_addr];

  jcs_ram_scanner #(.SETTLE(S), .DWELL(DW), .FIRST_ADDR(FA), .LAST_ADDR(LA)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stop(stop), .step(step),
    .step_mode(step_mode), .loop(loop), .ram_addr(ram_addr), .ram_sa(ram_sa),
    .ram_e(ram_e), .ram_data_in(ram_data_in), .cur_addr(cur_addr),
    .cur_data(cur_data), .busy(busy), .done(done), .word(word),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] a, input logic [7:0] d);
    string s;
    logic [31:0] w;
    s = $sformatf("%02x%02x", a, d);
    w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], s[i]};
    return w;
  endfunction

  // Model: each address occupies a slot; positions 0..S-1 set-address, S..2S-1
  // enable, then hold until the dwell elapses or a step click.
  bit          m_active, m_done;
  logic [7:0]  m_addr, m_cur_addr, m_cur_data;
  logic [31:0] m_word;
  int          m_pos, m_hold;

  always @(posedge CLK) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_addr = FA; m_cur_addr = 0; m_cur_data = 0;
      m_word = {4{8'h2D}}; m_pos = 0; m_hold = 0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1; m_done = 0; m_addr = FA; m_pos = 0;
      end
    end else if (stop) begin
      m_active = 0;
    end else if (m_pos < 2*S - 1) begin
      m_pos++;
    end else if (m_pos == 2*S - 1) begin
      m_cur_addr = m_addr; m_cur_data = mem[m_addr];
      m_word = exp_word(m_addr, mem[m_addr]);
      m_pos++; m_hold = 0;
    end else begin
      if (step_mode) m_hold = 0; else m_hold++;
      if (step_mode ? step : (m_hold == DW)) begin
        if (m_addr != LA) begin m_addr++; m_pos = 0; end
        else if (loop) begin m_addr = FA; m_pos = 0; end
        else begin m_active = 0; m_done = 1; end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ram_sa", 32'(ram_sa), 32'(m_active && m_pos < S));
      chk("ram_e", 32'(ram_e), 32'(m_active && m_pos >= S && m_pos < 2*S));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("cur_addr", 32'(cur_addr), 32'(m_cur_addr));
      chk("cur_data", 32'(cur_data), 32'(m_cur_data));
      chk("word", word, m_word);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic click_start();
    cyc = 0; start = 1; tick(); start = 0;
  endtask

  initial begin
    int sa_seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    tick(); chk_en = 1; tick(); tick(); reset = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word", word, 32'h2D2D2D2D);
    chk("rst_addr", 32'(ram_addr), 32'(FA));

    // Continuous scan 0..3
    click_start();
    chk("cs_sa1", 32'(ram_sa), 32'd1);
    go(2); chk("cs_sa2", 32'(ram_sa), 32'd1);
    go(3); chk("cs_e3", 32'({ram_sa, ram_e}), 32'b01);
    go(4); chk("cs_e4", 32'(ram_e), 32'd1);
    go(5); chk("cs_data5", 32'(cur_data), 32'h5A);
    chk("cs_word5", word, 32'h30303561);
    go(9); chk("cs_addr1", 32'({ram_addr, ram_sa}), {23'd0, 8'd1, 1'b1});
    go(32); chk("cs_done32", 32'(done), 32'd0);
    go(33); chk("cs_done33", 32'(done), 32'd1);
    chk("cs_last", {cur_addr, cur_data}, 32'h0359);
    chk("cs_lword", word, 32'h30333539);
    go(40);

    // Reset held three cycles in the first READ cycle
    click_start(); go(3);
    reset = 1; tick(); tick(); tick(); reset = 0;
    chk("mr_strobes", 32'({ram_sa, ram_e, busy, done}), 32'd0);
    chk("mr_data", 32'(cur_data), 32'd0);
    chk("mr_word", word, 32'h2D2D2D2D);
    tick();

    // Loop wraps to FIRST_ADDR
    loop = 1; click_start();
    go(33); chk("lp_wrap", 32'({ram_addr, ram_sa}), {23'd0, 8'd0, 1'b1});
    go(100); chk("lp_nodone", 32'(done), 32'd0);
    stop = 1; tick(); stop = 0; loop = 0; tick();

    // Step mode
    step_mode = 1; click_start();
    go(5); chk("st_first", 32'(cur_data), 32'h5A);
    sa_seen = 0;
    while (cyc < 205) begin tick(); if (ram_sa) sa_seen++; end
    chk("st_no_sa", 32'(sa_seen), 32'd0);
    step = 1; tick(); step = 0;
    chk("st_adv", 32'({ram_addr, ram_sa}), {23'd0, 8'd1, 1'b1});
    step = 1; tick(); step = 0;
    go(cyc + 10); chk("st_setaddr_step", 32'({ram_addr, ram_sa}), {23'd0, 8'd1, 1'b0});
    stop = 1; tick(); stop = 0; step_mode = 0;
    chk("st_stop", 32'(busy), 32'd0);

    // Abort in second READ cycle of address 2
    click_start(); go(20);
    chk("ab_read", 32'({ram_addr, ram_e}), {23'd0, 8'd2, 1'b1});
    stop = 1; tick(); stop = 0;
    chk("ab_strobe", 32'({ram_e, busy}), 32'd0);
    chk("ab_keep", {cur_addr, cur_data}, 32'h015B);
    chk("ab_word", word, 32'h30313562);

    // Contention
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("ct_idle", 32'({busy, ram_sa}), 32'd0);
    click_start(); go(6);
    start = 1; tick(); start = 0;
    go(9); chk("ct_hold", 32'({ram_addr, ram_sa}), {23'd0, 8'd1, 1'b1});
    stop = 1; tick(); stop = 0;

    // Random traffic
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (4000) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      step  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 149) == 0) loop = ~loop;
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    {start, stop, step, step_mode, loop, reset} = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
